// File: rtl/rcvr_frm.sv
// rcvr_frm: multi-lane serial frame receiver with per-lane CRC-16 trailer check and FWFT output FIFO
module rcvr_frm #(
    parameter int DATA_W      = 16,
    parameter int CH          = 2,
    parameter int FRAME_WORDS = 4,
    parameter int FIFO_DEPTH  = 8,
    parameter int CRC_EN      = 1
) (
    input  logic                 rst_n,
    input  logic                 i_clk,
    input  logic                 i_fs,
    input  logic [CH-1:0]        i_d,
    output logic [CH*DATA_W-1:0] o_data,
    output logic                 o_sof,
    output logic                 o_eof,
    output logic                 o_err,
    output logic                 o_vld,
    input  logic                 i_rdy,
    output logic                 o_ovf
);
    localparam int BW = $clog2(DATA_W);
    localparam int WW = $clog2(FRAME_WORDS);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int DW = CH * DATA_W;
    localparam int EW = DW + 3;
    localparam bit CE = CRC_EN != 0;

    typedef enum logic [1:0] {IDLE, DATA, CRC} state_t;
    state_t state, state_n;

    logic [BW-1:0] bit_cnt, e_bit;
    logic [WW-1:0] word_cnt, e_word;
    logic [3:0]    crc_cnt;
    logic [DW-1:0] sh, sh_nx, hold_data;
    logic [15:0]   crc [CH];
    logic [15:0]   crc_nx [CH];
    logic [CH-1:0] mis;
    logic          hold_vld, hold_sof;
    logic          active, abort, in_data, in_crc, word_done, last_word, crc_done;
    logic          p0, p1, wa, wb, ok_a, ok_b, pop;
    logic [EW-1:0] p0_ent, p1_ent, ea, head;
    logic [EW-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt, free;

    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        return {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    always_comb begin
        active    = i_fs || state != IDLE;
        abort     = i_fs && (state == CRC || (state == DATA && (bit_cnt != '0 || word_cnt != '0)));
        in_data   = i_fs || state == DATA;
        in_crc    = !i_fs && state == CRC;
        e_bit     = i_fs ? '0 : bit_cnt;
        e_word    = i_fs ? '0 : word_cnt;
        word_done = in_data && e_bit == BW'(DATA_W - 1);
        last_word = e_word == WW'(FRAME_WORDS - 1);
        crc_done  = in_crc && crc_cnt == 4'hF;
        state_n   = i_fs ? DATA : (word_done && last_word) ? (CE ? CRC : IDLE) : crc_done ? IDLE : state;
    end

    always_comb begin
        sh_nx = '0;
        mis   = '0;
        for (int c = 0; c < CH; c++) begin
            sh_nx[c*DATA_W +: DATA_W] = {sh[c*DATA_W +: DATA_W-1], i_d[c]};
            crc_nx[c] = crc_step(i_fs ? 16'hFFFF : crc[c], i_d[c]);
            mis[c]    = crc_nx[c] != 16'h0000;
        end
    end

    always_comb begin
        p0     = hold_vld && (abort || word_done || crc_done);
        p0_ent = {hold_data, hold_sof, abort || crc_done, abort || (crc_done && |mis)};
        p1     = !CE && word_done && last_word;
        p1_ent = {sh_nx, 1'b0, 1'b1, 1'b0};
        wa     = p0 || p1;
        wb     = p0 && p1;
        ea     = p0 ? p0_ent : p1_ent;
        pop    = o_vld && i_rdy;
        free   = (AW+1)'(FIFO_DEPTH) - cnt + (AW+1)'(pop);
        ok_a   = wa && free != '0;
        ok_b   = wb && free >= (AW+1)'(2);
    end

    always_ff @(negedge i_clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(negedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= '0;
            word_cnt  <= '0;
            crc_cnt   <= '0;
            sh        <= '0;
            hold_vld  <= 1'b0;
            hold_sof  <= 1'b0;
            hold_data <= '0;
            for (int c = 0; c < CH; c++) crc[c] <= '0;
        end else begin
            if (in_data) begin
                bit_cnt  <= word_done ? '0 : e_bit + BW'(1);
                word_cnt <= !word_done ? e_word : last_word ? '0 : e_word + WW'(1);
            end
            crc_cnt <= in_crc ? crc_cnt + 4'd1 : 4'd0;
            if (active) begin
                sh  <= sh_nx;
                crc <= crc_nx;
            end
            if (abort || crc_done) hold_vld <= 1'b0;
            else if (word_done) begin
                hold_vld  <= !p1;
                hold_data <= sh_nx;
                hold_sof  <= e_word == '0;
            end
        end
    end

    always_ff @(negedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            wp    <= '0;
            rp    <= '0;
            cnt   <= '0;
            o_ovf <= 1'b0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (ok_a) mem[wp] <= ea;
            if (ok_b) mem[wp + AW'(1)] <= p1_ent;
            wp  <= wp + AW'(ok_a) + AW'(ok_b);
            rp  <= rp + AW'(pop);
            cnt <= cnt + (AW+1)'(ok_a) + (AW+1)'(ok_b) - (AW+1)'(pop);
            if ((wa && !ok_a) || (wb && !ok_b)) o_ovf <= 1'b1;
        end
    end

    always_comb begin
        head  = mem[rp];
        o_vld = cnt != '0;
        {o_data, o_sof, o_eof, o_err} = o_vld ? head : '0;
    end
endmodule

// File: tb/tb_rcvr_frm.sv
// tb_rcvr_frm: scoreboard bench for rcvr_frm (16-bit words, 2 lanes, 4-word frames, 2-entry FIFO, CRC on)
module tb_rcvr_frm;
    logic        i_clk = 1'b0, rst_n = 1'b1, i_fs = 1'b0, i_rdy = 1'b1;
    logic [1:0]  i_d = 2'b00;
    logic [31:0] o_data;
    logic        o_sof, o_eof, o_err, o_vld, o_ovf;
    int          n_tests = 0, n_fail = 0;
    logic [34:0] q[$];

    localparam logic [63:0] A = 64'h123456789ABCDEF0;
    localparam logic [63:0] B = 64'h0F1E2D3C4B5A6978;
    localparam logic [63:0] C = 64'hA5A55A5AFFFF0000;

    rcvr_frm #(.DATA_W(16), .CH(2), .FRAME_WORDS(4), .FIFO_DEPTH(2), .CRC_EN(1)) dut (
        .rst_n(rst_n), .i_clk(i_clk), .i_fs(i_fs), .i_d(i_d),
        .o_data(o_data), .o_sof(o_sof), .o_eof(o_eof), .o_err(o_err),
        .o_vld(o_vld), .i_rdy(i_rdy), .o_ovf(o_ovf)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [15:0] crc16(input logic [63:0] v);
        logic [15:0] c = 16'hFFFF;
        for (int i = 63; i >= 0; i--) c = (c[15] ^ v[i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
        return c;
    endfunction

    function automatic logic [34:0] ent(input logic [63:0] l0, input int k, input logic sof, eof, err);
        logic [63:0] l1 = ~l0;
        return {l1[63-16*k -: 16], l0[63-16*k -: 16], sof, eof, err};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send(input logic [63:0] l0, input int nbits, input logic flip);
        logic [63:0] l1 = ~l0;
        logic [15:0] c0 = crc16(l0);
        logic [15:0] c1 = crc16(~l0) ^ {15'd0, flip};
        for (int i = 0; i < nbits; i++) begin
            @(posedge i_clk);
            i_fs = (i == 0);
            if (i < 64) i_d = {l1[63-i], l0[63-i]};
            else i_d = {c1[79-i], c0[79-i]};
        end
    endtask

    task automatic expect_frame(input logic [63:0] l0, input logic err);
        for (int k = 0; k < 4; k++) q.push_back(ent(l0, k, k == 0, k == 3, err && k == 3));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge i_clk);
            i_fs = 1'b0;
            i_d  = 2'b00;
        end
    endtask

    task automatic drain;
        int t = 0;
        while ((q.size() != 0 || o_vld) && t < 300) begin
            @(posedge i_clk);
            #2;
            t++;
        end
        chk("drain", q.size() + int'(o_vld), 0);
    endtask

    initial begin
        logic [34:0] e;
        forever begin
            @(posedge i_clk);
            #1;
            if (rst_n && o_vld && i_rdy) begin
                if (q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_entry: got %h expected none", {o_data, o_sof, o_eof, o_err});
                end else begin
                    e = q.pop_front();
                    chk("entry", {o_data, o_sof, o_eof, o_err}, e);
                end
            end
        end
    end

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("rst_vld", o_vld, 0);
        chk("rst_outs", {o_data, o_sof, o_eof, o_err, o_ovf}, 0);
        repeat (2) @(posedge i_clk);
        rst_n = 1'b1;

        expect_frame(A, 1'b0);
        send(A, 80, 1'b0);
        idle(2);
        drain();
        chk("ovf_clear", o_ovf, 0);

        expect_frame(A, 1'b1);
        send(A, 80, 1'b1);
        idle(2);
        drain();

        expect_frame(A, 1'b0);
        expect_frame(B, 1'b0);
        send(A, 80, 1'b0);
        send(B, 80, 1'b0);
        idle(2);
        drain();

        q.push_back(ent(A, 0, 1'b1, 1'b0, 1'b0));
        q.push_back(ent(A, 1, 1'b0, 1'b1, 1'b1));
        expect_frame(B, 1'b0);
        send(A, 37, 1'b0);
        send(B, 80, 1'b0);
        idle(2);
        drain();

        i_rdy = 1'b0;
        q.push_back(ent(A, 0, 1'b1, 1'b0, 1'b0));
        q.push_back(ent(A, 1, 1'b0, 1'b0, 1'b0));
        send(A, 80, 1'b0);
        send(B, 80, 1'b0);
        send(C, 80, 1'b0);
        idle(4);
        chk("ovf_set", o_ovf, 1);
        chk("ovf_vld", o_vld, 1);
        chk("ovf_head", {o_data, o_sof}, {~A[63:48], A[63:48], 1'b1});
        i_rdy = 1'b1;
        drain();
        chk("ovf_sticky", o_ovf, 1);

        i_rdy = 1'b0;
        send(C, 70, 1'b0);
        @(negedge i_clk);
        #2;
        chk("pre_rst_vld", o_vld, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_outs", {o_vld, o_data, o_sof, o_eof, o_err, o_ovf}, 0);
        @(posedge i_clk);
        i_fs  = 1'b0;
        i_d   = 2'b00;
        i_rdy = 1'b1;
        @(posedge i_clk);
        rst_n = 1'b1;
        expect_frame(B, 1'b0);
        send(B, 80, 1'b0);
        idle(2);
        drain();
        chk("post_rst_ovf", o_ovf, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/rcvr_frm.md
# rcvr_frm

Parametrised multi-lane serial frame receiver, the successor of the single-lane 16-bit word receiver on the contr link. It deserialises CH parallel data lanes that share one serial clock and one frame-sync line, and assembles fixed-length frames of FRAME_WORDS words per lane. When CRC_EN=1 it checks a per-lane CRC-16 trailer. Complete words, tagged with frame markers and an error flag, are buffered in a small first-word-fall-through (FWFT) FIFO behind a valid/ready handshake for the downstream frame processor.

## Interface
- DATA_W, 16: bits per word per lane (4..32).
- CH, 2: number of data lanes (1..8).
- FRAME_WORDS, 4: data words per frame (2..256).
- FIFO_DEPTH, 8: output FIFO entries, power of two (2..64).
- CRC_EN, 1: 1 enables a 16-bit CRC trailer after each frame; 0 means no trailer.

- rst_n  in  1  asynchronous active-low reset; single clock domain; all flops clear on the falling edge of rst_n.
- i_clk  in  1  serial bit clock; all state updates and samples happen on the falling edge.
- i_fs  in  1  frame sync; high on the edge where the first bit (MSB of word 0) is sampled.
- i_d  in  CH  serial data, one bit per lane, MSB first.
- o_data  out  CH*DATA_W  FIFO head word; lane c occupies bits [c*DATA_W +: DATA_W].
- o_sof  out  1  head is word 0 of a frame.
- o_eof  out  1  head is the last word delivered for a frame.
- o_err  out  1  valid with o_eof: CRC mismatch on any lane, or frame aborted.
- o_vld  out  1  FIFO not empty.
- i_rdy  in  1  downstream accepts the head when o_vld && i_rdy at a falling edge.
- o_ovf  out  1  sticky: a push was lost because the FIFO was full; cleared only by reset.

## Operation
- FSM states:
  - IDLE: waits for i_fs=1; that edge samples bit 0 and the FSM moves to DATA.
  - DATA: bit counter 0..DATA_W-1 and word counter 0..FRAME_WORDS-1.
  - CRC: 16-bit counter; only exists when CRC_EN=1.
  - After the last DATA bit (CRC_EN=0) or the last CRC bit, the FSM returns to IDLE.
  - An i_fs=1 on the very next edge starts a back-to-back frame with no gap.
- Shift: per lane, shift_reg <= {shift_reg[DATA_W-2:0], i_d[c]} on every edge while in DATA or CRC.
- One-word holding stage:
  - A completed word is not pushed immediately. It goes into a hold register (data plus sof tag).
  - The previously held word is pushed with eof=0.
  - The last data word stays held through the CRC phase. It is pushed at the final CRC bit with eof=1 and err set to the OR of the lane mismatches.
  - With CRC_EN=0 the last word is pushed as soon as it completes, with eof=1 and err=0.
- CRC per lane:
  - CRC-16-CCITT, polynomial 0x1021, initial value 0xFFFF, no reflection, no final XOR.
  - Updated bitwise over all FRAME_WORDS*DATA_W data bits, MSB first.
  - The received 16-bit trailer, MSB first, must equal the computed value.
- Abort:
  - Trigger: i_fs=1 while in DATA (bit counter ≠ 0 or word ≠ 0) or while in CRC.
  - The partial word is discarded.
  - If a word is held, it is pushed with eof=1, err=1.
  - The fs edge is treated as bit 0 of a new frame, and the FSM stays in or enters DATA.
- Overflow:
  - A push while the FIFO is full (pops on the same edge are taken into account) is dropped and sets o_ovf.
  - Later entries still push once space frees.
  - A simultaneous push and pop on a full FIFO succeeds.
- Reset mid-frame: FSM goes to IDLE, FIFO empties, the hold register clears. No partial frame survives.

## Timing
- Reset values: o_vld=0, o_sof=0, o_eof=0, o_err=0, o_ovf=0, o_data=0.
- FIFO is FWFT: an entry pushed at edge N drives o_vld=1 and the head fields from edge N; a pop at edge N advances the head from edge N.
- Push edges, with t0 = fs edge:
  - Word k < FRAME_WORDS-1 is pushed at edge t0 + (k+2)*DATA_W - 1.
  - The last word is pushed at edge t0 + FRAME_WORDS*DATA_W + 15 when CRC_EN=1.
  - The last word is pushed at edge t0 + FRAME_WORDS*DATA_W - 1 when CRC_EN=0.
- Frame length: FRAME_WORDS*DATA_W + 16*CRC_EN bits; the next fs is legal on the following edge.
- i_fs is ignored in IDLE only when low. i_fs=1 in any other state triggers an abort.

## Test plan
- Nominal frame (DATA_W=16, CH=2, FRAME_WORDS=4):
  - Stimulus: lane0 = 0x1234, 0x5678, 0x9ABC, 0xDEF0 with a correct CRC trailer; lane1 = the bitwise inverse with its correct CRC; i_rdy=1.
  - Response: 4 pops; sof on the first, eof on the fourth, err=0; o_data[15:0]=0x1234 and o_data[31:16]=0xEDCB first.
- CRC error: same frame with bit 0 of lane1's trailer flipped -> the fourth entry has eof=1, err=1; data unchanged.
- Back-to-back frames: two frames with fs on the edge right after the last CRC bit -> 8 entries, sof at entries 0 and 4, eof at entries 3 and 7, no err.
- Abort: fs asserted at bit 5 of word 2 -> entries word0 (sof) and word1 (eof, err=1); the new frame then delivers 4 clean words.
- Overflow: FIFO_DEPTH=2, i_rdy=0 for 3 frames, then i_rdy=1 -> exactly 2 entries pop, o_ovf=1 and stays 1.
- Reset: rst_n low mid-CRC -> all outputs 0 immediately; the next fs frame is received correctly.
